// File: rtl/smi_pkg.sv
// Shared SMI flit definitions: eofc width, scale-up lane geometry and
// byte-valid helpers used by the flit width converters.
package smi_pkg;

  localparam int SMI_EOFC_W      = 8;
  localparam int SMI_SCALE_LANES = 8;
  localparam int SMI_LANE_W      = $clog2(SMI_SCALE_LANES);

  typedef logic [SMI_EOFC_W-1:0] smi_eofc_t;

  function automatic logic smiEofcIsEnd(smi_eofc_t eofc);
    return eofc != '0;
  endfunction

  // Bit idx of the byte-valid mask: mid-frame flits are fully valid.
  function automatic logic smiByteValid(smi_eofc_t eofc, int idx);
    return !smiEofcIsEnd(eofc) || (SMI_EOFC_W'(idx) < eofc);
  endfunction

endpackage

// File: rtl/smi_flit_hold_reg.sv
// One-entry Ready/Stop output register; a load in the same cycle as a
// drain simply replaces the entry so the output never bubbles.
module smi_flit_hold_reg #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             loadValid,
  input  logic [Width-1:0] loadData,
  input  logic             outStop,
  output logic             full,
  output logic [Width-1:0] data
);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      full <= 1'b0;
      data <= '0;
    end else if (loadValid) begin
      full <= 1'b1;
      data <= loadData;
    end else if (full && !outStop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/smi_flit_scale_u8.sv
// x8 SMI flit widener: packs eight narrow flits into one wide flit,
// flushing early at frame end with a corrected eofc.
module smi_flit_scale_u8
  import smi_pkg::*;
#(
  parameter int FlitWidth = 8
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth-1:0]   smiInData,
  output logic                   smiInStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop
);

  localparam int InBytes  = FlitWidth / 8;
  localparam int OutWidth = FlitWidth * SMI_SCALE_LANES;

  typedef logic [SMI_LANE_W-1:0] lane_t;

  localparam lane_t LastLane = lane_t'(SMI_SCALE_LANES - 1);

  lane_t                lane;
  logic [FlitWidth-1:0] acc [SMI_SCALE_LANES];

  logic                 holdFull;
  logic                 accept;
  logic                 isEnd;
  logic                 complete;
  smi_eofc_t            nSat;
  smi_eofc_t            compEofc;
  logic [FlitWidth-1:0] inMasked;
  logic [OutWidth-1:0]  compData;

  // Stop depends only on registered state and downstream Stop.
  assign smiInStop   = holdFull & smiOutStop;
  assign smiOutReady = holdFull;

  assign accept   = smiInReady & ~smiInStop;
  assign isEnd    = smiEofcIsEnd(smiInEofc);
  assign complete = accept & (isEnd | (lane == LastLane));

  always_comb begin
    nSat = smiInEofc;
    if (smiInEofc > SMI_EOFC_W'(InBytes)) begin
      nSat = SMI_EOFC_W'(InBytes);
    end
  end

  always_comb begin
    inMasked = '0;
    for (int b = 0; b < InBytes; b++) begin
      if (smiByteValid(nSat, b)) begin
        inMasked[b*8 +: 8] = smiInData[b*8 +: 8];
      end
    end
  end

  always_comb begin
    compEofc = '0;
    if (isEnd) begin
      compEofc = SMI_EOFC_W'(lane) * SMI_EOFC_W'(InBytes) + nSat;
    end
  end

  always_comb begin
    compData = '0;
    for (int k = 0; k < SMI_SCALE_LANES; k++) begin
      if (lane_t'(k) < lane) begin
        compData[k*FlitWidth +: FlitWidth] = acc[k];
      end else if (lane_t'(k) == lane) begin
        compData[k*FlitWidth +: FlitWidth] = inMasked;
      end
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      lane <= '0;
      for (int k = 0; k < SMI_SCALE_LANES; k++) begin
        acc[k] <= '0;
      end
    end else if (accept) begin
      if (complete) begin
        lane <= '0;
        for (int k = 0; k < SMI_SCALE_LANES; k++) begin
          acc[k] <= '0;
        end
      end else begin
        acc[lane] <= smiInData;
        lane      <= lane + lane_t'(1);
      end
    end
  end

  smi_flit_hold_reg #(
    .Width(SMI_EOFC_W + OutWidth)
  ) uHold (
    .clk      (clk),
    .srst     (srst),
    .loadValid(complete),
    .loadData ({compEofc, compData}),
    .outStop  (smiOutStop),
    .full     (holdFull),
    .data     ({smiOutEofc, smiOutData})
  );

endmodule

// File: tb/tb_smi_flit_scale_u8.sv
// Bench for smi_flit_scale_u8: byte-level reference model plus directed
// vectors on an 8-bit and a 32-bit instance.
module tb_smi_flit_scale_u8;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  logic        dReady [2];
  logic [7:0]  dEofc  [2];
  logic [31:0] dData  [2];
  logic        dStop  [2];

  logic         obsStop  [2];
  logic         obsReady [2];
  logic [7:0]   obsEofc  [2];
  logic [255:0] obsData  [2];

  logic         inStop0, outReady0, inStop1, outReady1;
  logic [7:0]   outEofc0, outEofc1;
  logic [63:0]  outData0;
  logic [255:0] outData1;

  smi_flit_scale_u8 #(.FlitWidth(8)) dut0 (
    .clk(clk), .srst(srst),
    .smiInReady(dReady[0]), .smiInEofc(dEofc[0]),
    .smiInData(dData[0][7:0]), .smiInStop(inStop0),
    .smiOutReady(outReady0), .smiOutEofc(outEofc0),
    .smiOutData(outData0), .smiOutStop(dStop[0])
  );

  smi_flit_scale_u8 #(.FlitWidth(32)) dut1 (
    .clk(clk), .srst(srst),
    .smiInReady(dReady[1]), .smiInEofc(dEofc[1]),
    .smiInData(dData[1]), .smiInStop(inStop1),
    .smiOutReady(outReady1), .smiOutEofc(outEofc1),
    .smiOutData(outData1), .smiOutStop(dStop[1])
  );

  assign obsStop[0]  = inStop0;
  assign obsStop[1]  = inStop1;
  assign obsReady[0] = outReady0;
  assign obsReady[1] = outReady1;
  assign obsEofc[0]  = outEofc0;
  assign obsEofc[1]  = outEofc1;
  assign obsData[0]  = {192'h0, outData0};
  assign obsData[1]  = outData1;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, int d,
                       logic [255:0] act, logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h",
               name, d, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]   e;
    logic [255:0] dat;
  } ent_t;

  ent_t logQ0[$];
  ent_t logQ1[$];

  // Reference model: bytes appended at a running offset; a wide flit is
  // emitted after eight flits or at frame end.
  logic         mFull  [2];
  logic [7:0]   mEofc  [2];
  logic [255:0] mData  [2];
  logic [255:0] mAcc   [2];
  int           mLanes [2];

  function automatic int ibOf(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (srst) begin
        check("rst_ready", d, 256'(obsReady[d]), 256'(0));
        check("rst_stop", d, 256'(obsStop[d]), 256'(0));
        check("rst_eofc", d, 256'(obsEofc[d]), 256'(0));
        check("rst_data", d, obsData[d], 256'(0));
        mFull[d] = 1'b0; mEofc[d] = '0; mData[d] = '0;
        mAcc[d] = '0; mLanes[d] = 0;
      end else begin
        logic expStop, acc, drain;
        int   n, nb, ib;
        expStop = mFull[d] & dStop[d];
        check("in_stop", d, 256'(obsStop[d]), 256'(expStop));
        check("out_ready", d, 256'(obsReady[d]), 256'(mFull[d]));
        if (mFull[d]) begin
          check("out_eofc", d, 256'(obsEofc[d]), 256'(mEofc[d]));
          check("out_data", d, obsData[d], mData[d]);
        end
        if (obsReady[d] && !dStop[d]) begin
          if (d == 0) logQ0.push_back('{obsEofc[d], obsData[d]});
          else        logQ1.push_back('{obsEofc[d], obsData[d]});
        end
        acc   = dReady[d] && !expStop;
        drain = mFull[d] && !dStop[d];
        if (drain) mFull[d] = 1'b0;
        if (acc) begin
          ib = ibOf(d);
          n  = int'(dEofc[d]);
          if (n > ib) n = ib;
          nb = (n != 0) ? n : ib;
          for (int b = 0; b < nb; b++) begin
            mAcc[d][(mLanes[d]*ib + b)*8 +: 8] = dData[d][b*8 +: 8];
          end
          if (n != 0 || mLanes[d] == 7) begin
            mFull[d]  = 1'b1;
            mEofc[d]  = (n != 0) ? 8'(mLanes[d]*ib + n) : 8'h0;
            mData[d]  = mAcc[d];
            mAcc[d]   = '0;
            mLanes[d] = 0;
          end else begin
            mLanes[d]++;
          end
        end
      end
    end
  end

  int stallSum;

  task automatic send(int d, logic [7:0] e, logic [31:0] v);
    logic ok;
    int   waited;
    waited = 0;
    ok = 1'b0;
    dReady[d] = 1'b1;
    dEofc[d]  = e;
    dData[d]  = v;
    while (!ok && waited < 200) begin
      @(negedge clk);
      ok = !obsStop[d];
      @(posedge clk);
      #1;
      if (!ok) waited++;
    end
    if (!ok) check("send_timeout", d, 256'(0), 256'(1));
    stallSum += waited;
    dReady[d] = 1'b0;
    dEofc[d]  = '0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectOut(string name, int d,
                           logic [7:0] e, logic [255:0] v);
    ent_t x;
    int   sz;
    sz = (d == 0) ? logQ0.size() : logQ1.size();
    check({name, "_present"}, d, 256'(sz != 0), 256'(1));
    if (sz != 0) begin
      x = (d == 0) ? logQ0.pop_front() : logQ1.pop_front();
      check({name, "_eofc"}, d, 256'(x.e), 256'(e));
      check({name, "_data"}, d, x.dat, v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp;
    time          t0;
    srst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      dReady[d] = 1'b0; dEofc[d] = '0;
      dData[d]  = '0;   dStop[d] = 1'b0;
    end
    stallSum = 0;
    idle(2);
    srst = 1'b0;
    idle(1);

    // Full group, frame end on lane 7
    for (int i = 0; i < 8; i++) begin
      send(0, (i == 7) ? 8'd1 : 8'd0, 32'(8'h11 * (i + 1)));
    end
    check("t1_latency", 0, 256'(obsReady[0]), 256'(1));
    idle(3);
    expectOut("t1", 0, 8'd8, 256'h8877665544332211);

    // Short frame, then a one-flit frame from lane 0
    send(0, 8'd0, 32'hA1);
    send(0, 8'd0, 32'hA2);
    send(0, 8'd1, 32'hA3);
    send(0, 8'd1, 32'h5C);
    idle(3);
    expectOut("t2a", 0, 8'd3, 256'h0000000000A3A2A1);
    expectOut("t2b", 0, 8'd1, 256'h5C);

    // Backpressure across two groups
    stallSum = 0;
    dStop[0] = 1'b1;
    fork
      for (int i = 0; i < 16; i++) begin
        send(0, (i == 15) ? 8'd1 : 8'd0, 32'(8'h40 + i));
      end
      begin
        repeat (30) @(posedge clk);
        #1;
        dStop[0] = 1'b0;
      end
    join
    check("t3_stalled", 0, 256'(stallSum > 0), 256'(1));
    idle(3);
    expectOut("t3a", 0, 8'd0, 256'h4746454443424140);
    expectOut("t3b", 0, 8'd8, 256'h4F4E4D4C4B4A4948);

    // Throughput: 64 bytes back-to-back
    stallSum = 0;
    t0 = $time;
    for (int i = 0; i < 64; i++) begin
      send(0, (i == 63) ? 8'd1 : 8'd0, 32'(i));
    end
    check("t4_cycles", 0, 256'(($time - t0) / 10), 256'(64));
    check("t4_stalls", 0, 256'(stallSum), 256'(0));
    idle(3);
    check("t4_count", 0, 256'(logQ0.size()), 256'(8));
    for (int g = 0; g < 8; g++) begin
      exp = '0;
      for (int j = 0; j < 8; j++) exp[j*8 +: 8] = 8'(g*8 + j);
      expectOut("t4", 0, (g == 7) ? 8'd8 : 8'd0, exp);
    end

    // 32-bit variant: end at lane 5, saturation, lane-0 end
    for (int k = 0; k < 5; k++) send(1, 8'd0, 32'h1000_0000 + k);
    send(1, 8'd2, 32'hDEADBEEF);
    send(1, 8'd9, 32'hCAFEF00D);
    send(1, 8'd1, 32'h12345678);
    idle(3);
    expectOut("t5a", 1, 8'd22,
              {64'h0, 32'h0000BEEF, 32'h10000004, 32'h10000003,
               32'h10000002, 32'h10000001, 32'h10000000});
    expectOut("t5b", 1, 8'd4, 256'hCAFEF00D);
    expectOut("t5c", 1, 8'd1, 256'h78);

    // Async reset mid-frame with a pending wide flit
    send(0, 8'd0, 32'h31);
    send(0, 8'd0, 32'h32);
    send(0, 8'd0, 32'h33);
    dStop[1] = 1'b1;
    send(1, 8'd4, 32'h0BADF00D);
    check("t6_pend", 1, 256'(obsReady[1]), 256'(1));
    check("t6_pstop", 1, 256'(obsStop[1]), 256'(1));
    @(posedge clk);
    #3;
    srst = 1'b1;
    #1;
    check("t6_ready", 1, 256'(obsReady[1]), 256'(0));
    check("t6_stop", 1, 256'(obsStop[1]), 256'(0));
    check("t6_eofc", 1, 256'(obsEofc[1]), 256'(0));
    check("t6_data", 1, obsData[1], 256'(0));
    @(posedge clk);
    #1;
    srst = 1'b0;
    dStop[0] = 1'b0;
    dStop[1] = 1'b0;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      send(0, (i == 7) ? 8'd1 : 8'd0, 32'(i + 1));
    end
    idle(3);
    check("t6_cnt0", 0, 256'(logQ0.size()), 256'(1));
    check("t6_cnt1", 1, 256'(logQ1.size()), 256'(0));
    expectOut("t6", 0, 8'd8, 256'h0807060504030201);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/smi_flit_scale_u8.md
Name: smi_flit_scale_u8

Overview:
- Widens SMI flits by a factor of 8: packs 8 consecutive narrow input flits into one wide output flit.
- It is the upstream counterpart of the x8 flit-reduction block. It sits on the receive side of narrow SMI links (e.g. byte-serial endpoints) and feeds wide internal SMI datapaths.
- Preserves frame boundaries. A frame that ends part-way through a wide flit is flushed early with a corrected end-of-frame count.

Parameters:
- FlitWidth, 8, output flit data width in bytes; integer power of two, minimum 8. Input data width is FlitWidth bits, i.e. FlitWidth/8 bytes, called InBytes below.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- srst  input  1  reset, asynchronous, active-high; clears all state immediately on assertion.
- smiInReady  input  1  input flit valid.
- smiInEofc  input  8  0 means a mid-frame flit; N in 1..InBytes means the last flit of the frame, with N valid low-order bytes.
- smiInData  input  FlitWidth  narrow flit data.
- smiInStop  output  1  input backpressure.
- smiOutReady  output  1  output flit valid.
- smiOutEofc  output  8  0 means a mid-frame flit; N in 1..FlitWidth means end of frame with N valid bytes.
- smiOutData  output  FlitWidth*8  wide flit data.
- smiOutStop  input  1  output backpressure.

Behaviour:
- Handshake:
  - A transfer occurs on a clock edge where Ready=1 and Stop=0.
  - Once smiOutReady is asserted, smiOutReady, smiOutEofc and smiOutData stay stable until transferred.
- Reset values: smiOutReady=0, smiOutEofc=0, smiOutData=0, smiInStop=0. Lane counter=0, accumulator=0, hold register empty.
- State:
  - Lane counter L, 3 bits, 0..7.
  - Accumulator of 8 lanes.
  - One-entry output hold register (full flag, eofc, data).
- Packing is little-endian: input flit k of a group goes to smiOutData[(k+1)*FlitWidth-1 : k*FlitWidth].
- On an accepted input with eofc=0:
  - If L<7: write the lane, then L <= L+1.
  - If L=7: complete the group; load the hold register with eofc=0 and the 8 lanes; L <= 0.
- On an accepted input with eofc=N≠0, at any L:
  - Complete the group immediately.
  - Output eofc = L*InBytes + N.
  - Lanes above L are zero, and bytes above the valid count within lane L are zeroed.
  - L <= 0 and the accumulator is cleared.
- Eofc values above InBytes are saturated to InBytes.
- Latency: smiOutReady rises on the cycle after the completing input flit is accepted.
- smiInStop = holdFull & smiOutStop.
  - This is combinational. It is the only combinational input-to-output path (Stop to Stop); there is no path from Ready to Stop.
  - It guarantees the hold register can always absorb or drain a completion.
- Simultaneous drain and load in the same cycle (hold register full, smiOutStop=0, completing input accepted): the hold register reloads with the new flit and smiOutReady stays 1, with no bubble.
- Throughput: one input flit per cycle sustained when smiOutStop=0.
  - Back-to-back frames need no idle cycle.
  - A 1-flit frame produces a wide flit with eofc=N.
- Hold register full, smiOutStop=1, non-completing input: the input is still blocked, since smiInStop=1 regardless of input content.
- Reset mid-frame: the partial group is discarded and the pending output is dropped. The first flit after reset goes to lane 0.
- A frame-end flit at L=0 is legal: the output carries only lane 0.

Decomposition:
- Shared package (smi_pkg):
  - SMI_EOFC_W=8.
  - SMI_SCALE_LANES=8 and its 3-bit lane-index width.
  - A function giving the byte-valid mask from an eofc value.
  - The eofc-is-end predicate.
- One sub-module: smi_flit_hold_reg.
  - One-entry, parameterised-width Ready/Stop output register with the simultaneous load/drain rule above.
  - Reusable by other scale-up variants.

Test Plan:
- FlitWidth=8, full group (smiOutStop=0 throughout). Inputs 0x11,0x22,…,0x88, with eofc=0 except the last, which has eofc=1 → one output, data 0x8877665544332211, eofc=8, one cycle after the last accept.
- Short frame. Inputs 0xA1, 0xA2, then 0xA3 with eofc=1 → data 0x0000000000A3A2A1, eofc=3. The next frame starts at lane 0.
- Backpressure.
  - Stimulus: smiOutStop=1 while 16 bytes arrive, then release.
  - Required: the first group is held stable; smiInStop=1 from the cycle the hold register fills; no data is lost or duplicated; both groups emerge in order.
- Throughput. 64 back-to-back bytes with smiOutStop=0 → 8 outputs, no input stall, smiInStop constantly 0.
- Width variant. FlitWidth=32 (InBytes=4). Frame-end at lane 5 with eofc=2 and data 0xDEADBEEF → output eofc=22. Lane 5 is 0x0000BEEF and lanes 6–7 are zero.
- Async reset.
  - Stimulus: assert srst between clock edges after 3 bytes of a frame.
  - Required: outputs clear immediately. The post-reset group 0x01..0x08 → data 0x0807060504030201, eofc per its end flit.
